// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared definitions for the LDPC iteration scheduler and its
// node datapaths.
//   state_t      - scheduler FSM states
//   cnt_width()  - bits needed to hold the values 0..n
//   DEF_*        - default code geometry shared with the VN/CN datapaths
package ldpc_pkg;

  localparam int DEF_N_VN     = 16;
  localparam int DEF_N_CN     = 8;
  localparam int DEF_MAX_ITER = 10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_CN_ISSUE = 3'd2,
    S_CN_WAIT  = 3'd3,
    S_VN_ISSUE = 3'd4,
    S_FIN      = 3'd5
  } state_t;

  // Width of a counter that must reach n itself (not just n-1).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ldpc_iter_sched_if.sv
// ldpc_iter_sched_if: command/response bundle between the iteration
// scheduler (master) and the node datapaths plus decode controller (slave).
//   start                       - begin a decode
//   dp_ready                    - datapath accepts the issued command
//   ld_en/ld_addr               - channel-LLR load command
//   cn_en/cn_addr               - check-node update command
//   vn_en/vn_addr               - variable-node update command
//   cn_rsp_valid/cn_parity_ok   - one returned check-node parity result
//   busy/done/converged/iter_cnt- decode status
interface ldpc_iter_sched_if #(
  parameter int ADDR_W = 5,
  parameter int ITER_W = 4
);
  logic              start;
  logic              dp_ready;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic              cn_en;
  logic [ADDR_W-1:0] cn_addr;
  logic              vn_en;
  logic [ADDR_W-1:0] vn_addr;
  logic              cn_rsp_valid;
  logic              cn_parity_ok;
  logic              busy;
  logic              done;
  logic              converged;
  logic [ITER_W-1:0] iter_cnt;

  modport master (
    input  start, dp_ready, cn_rsp_valid, cn_parity_ok,
    output ld_en, ld_addr, cn_en, cn_addr, vn_en, vn_addr,
           busy, done, converged, iter_cnt
  );

  modport slave (
    output start, dp_ready, cn_rsp_valid, cn_parity_ok,
    input  ld_en, ld_addr, cn_en, cn_addr, vn_en, vn_addr,
           busy, done, converged, iter_cnt
  );
endinterface

// File: rtl/ldpc_addr_seq.sv
// ldpc_addr_seq: handshaked index sequencer. A start pulse arms the
// sequencer; from the next cycle it presents en with addr 0, advancing by
// one per accepted transfer (en && ready) up to COUNT-1, then drops en.
//   clk, rst_n - clock, async active-low reset
//   start      - arm a new sweep from index 0
//   ready      - downstream accepts the presented index
//   en, addr   - registered command valid / index, stable until accepted
//   last       - the final index is transferring this cycle
module ldpc_addr_seq #(
  parameter int ADDR_W = 5,
  parameter int COUNT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ready,
  output logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COUNT - 1);

  assign last = en && ready && (addr == LAST_ADDR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en   <= 1'b0;
      addr <= '0;
    end else if (start) begin
      en   <= 1'b1;
      addr <= '0;
    end else if (en && ready) begin
      if (addr == LAST_ADDR) begin
        en <= 1'b0;
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/ldpc_iter_sched.sv
// ldpc_iter_sched: iteration scheduler for a flooding LDPC decoder.
// Loads channel LLRs, then alternates CN and VN sweeps over the shared
// node datapaths, folding returned check parities into a syndrome flag.
// Stops on the iteration limit, or on a zero syndrome when early
// termination is built in.
//   clk, rst_n - clock, async active-low reset
//   bus        - ldpc_iter_sched_if.master (commands, responses, status)
// Build option: define LDPC_EARLY_TERM_EN to exit as soon as a CN sweep
// reports every check satisfied; otherwise exactly MAX_ITER VN sweeps run
// and converged reports the syndrome of the final CN sweep.
module ldpc_iter_sched
  import ldpc_pkg::*;
#(
  parameter int N_VN     = DEF_N_VN,
  parameter int N_CN     = DEF_N_CN,
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int ADDR_W   = 5,
  parameter int ITER_W   = 4
) (
  input logic               clk,
  input logic               rst_n,
  ldpc_iter_sched_if.master bus
);
  localparam int                RSP_W    = cnt_width(N_CN);
  localparam logic [RSP_W-1:0]  RSP_FULL = RSP_W'(N_CN);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  state_t            state, state_nxt;
  logic [RSP_W-1:0]  rsp_cnt, rsp_cnt_nxt;
  logic              syn_ok, syn_ok_nxt;
  logic [ITER_W-1:0] iter_cnt;
  logic              converged;
  logic              ld_start, cn_start, vn_start;
  logic              ld_last, cn_last, vn_last;
  logic              clr_run, iter_inc, fin_entry;
  logic              rsp_take, stop;

  ldpc_addr_seq #(.ADDR_W(ADDR_W), .COUNT(N_VN)) u_ld_seq (
    .clk(clk), .rst_n(rst_n), .start(ld_start), .ready(bus.dp_ready),
    .en(bus.ld_en), .addr(bus.ld_addr), .last(ld_last)
  );

  ldpc_addr_seq #(.ADDR_W(ADDR_W), .COUNT(N_CN)) u_cn_seq (
    .clk(clk), .rst_n(rst_n), .start(cn_start), .ready(bus.dp_ready),
    .en(bus.cn_en), .addr(bus.cn_addr), .last(cn_last)
  );

  ldpc_addr_seq #(.ADDR_W(ADDR_W), .COUNT(N_VN)) u_vn_seq (
    .clk(clk), .rst_n(rst_n), .start(vn_start), .ready(bus.dp_ready),
    .en(bus.vn_en), .addr(bus.vn_addr), .last(vn_last)
  );

  // Responses count only during a CN sweep and only up to N_CN; the
  // "next" values let CN_WAIT decide in the same cycle the last one lands.
  always_comb begin
    rsp_take    = bus.cn_rsp_valid && (rsp_cnt != RSP_FULL) &&
                  ((state == S_CN_ISSUE) || (state == S_CN_WAIT));
    rsp_cnt_nxt = rsp_take ? rsp_cnt + 1'b1 : rsp_cnt;
    syn_ok_nxt  = syn_ok && (!rsp_take || bus.cn_parity_ok);
`ifdef LDPC_EARLY_TERM_EN
    stop = syn_ok_nxt || (iter_cnt == ITER_MAX);
`else
    stop = (iter_cnt == ITER_MAX);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    ld_start  = 1'b0;
    cn_start  = 1'b0;
    vn_start  = 1'b0;
    clr_run   = 1'b0;
    iter_inc  = 1'b0;
    fin_entry = 1'b0;
    case (state)
      S_IDLE: if (bus.start) begin
        state_nxt = S_LOAD;
        ld_start  = 1'b1;
        clr_run   = 1'b1;
      end
      S_LOAD: if (ld_last) begin
        state_nxt = S_CN_ISSUE;
        cn_start  = 1'b1;
      end
      S_CN_ISSUE: if (cn_last) state_nxt = S_CN_WAIT;
      S_CN_WAIT: if (rsp_cnt_nxt == RSP_FULL) begin
        if (stop) begin
          state_nxt = S_FIN;
          fin_entry = 1'b1;
        end else begin
          state_nxt = S_VN_ISSUE;
          vn_start  = 1'b1;
        end
      end
      S_VN_ISSUE: if (vn_last) begin
        state_nxt = S_CN_ISSUE;
        cn_start  = 1'b1;
        iter_inc  = 1'b1;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_cnt   <= '0;
      syn_ok    <= 1'b0;
      iter_cnt  <= '0;
      converged <= 1'b0;
    end else begin
      // A new CN sweep starts from a clean syndrome.
      if (cn_start) begin
        rsp_cnt <= '0;
        syn_ok  <= 1'b1;
      end else begin
        rsp_cnt <= rsp_cnt_nxt;
        syn_ok  <= syn_ok_nxt;
      end
      if (clr_run)       iter_cnt <= '0;
      else if (iter_inc) iter_cnt <= iter_cnt + 1'b1;
      if (clr_run)         converged <= 1'b0;
      else if (fin_entry)  converged <= syn_ok_nxt;
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_FIN);
  assign bus.converged = converged;
  assign bus.iter_cnt  = iter_cnt;
endmodule

// File: tb/tb_ldpc_iter_sched.sv
// tb_ldpc_iter_sched: directed bench for ldpc_iter_sched with N_VN=4,
// N_CN=2, MAX_ITER=3. Expected results follow LDPC_EARLY_TERM_EN as built.
module tb_ldpc_iter_sched;
  localparam int N_VN = 4;
  localparam int N_CN = 2;
  localparam int MAX_I = 3;
`ifdef LDPC_EARLY_TERM_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ldpc_iter_sched_if #(.ADDR_W(5), .ITER_W(4)) bus ();

  ldpc_iter_sched #(
    .N_VN(N_VN), .N_CN(N_CN), .MAX_ITER(MAX_I), .ADDR_W(5), .ITER_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Bench-side datapath model.
  logic       ready_v, bp_mode, dly_mode, resp_ok;
  logic       tog = 1'b0;
  logic [5:0] dly_sr = '0;

  assign bus.dp_ready     = (bp_mode && bus.vn_en) ? tog : ready_v;
  // Delayed mode: each CN transfer answers 5 cycles later, and one extra
  // bad response follows every burst.
  assign bus.cn_rsp_valid = dly_mode ? (dly_sr[4] | dly_sr[5])
                                     : (bus.cn_en && bus.dp_ready);
  assign bus.cn_parity_ok = dly_mode ? (dly_sr[4] & resp_ok) : resp_ok;

  // Transfer monitor.
  int   ld_log[$], cn_log[$], vn_log[$];
  int   ld_en_cyc = 0, cn_en_cyc = 0, done_cnt = 0, hold_bad = 0, stalls = 0;
  logic stall_q = 1'b0;
  logic [4:0] stall_addr = '0;

  always @(posedge clk) begin
    if (bus.ld_en && bus.dp_ready) ld_log.push_back(int'(bus.ld_addr));
    if (bus.cn_en && bus.dp_ready) cn_log.push_back(int'(bus.cn_addr));
    if (bus.vn_en && bus.dp_ready) vn_log.push_back(int'(bus.vn_addr));
    if (bus.ld_en) ld_en_cyc <= ld_en_cyc + 1;
    if (bus.cn_en) cn_en_cyc <= cn_en_cyc + 1;
    if (bus.done)  done_cnt  <= done_cnt + 1;
    if (stall_q && (!bus.vn_en || bus.vn_addr != stall_addr)) hold_bad <= hold_bad + 1;
    if (bus.vn_en && !bus.dp_ready) stalls <= stalls + 1;
    stall_q    <= bus.vn_en && !bus.dp_ready;
    stall_addr <= bus.vn_addr;
    tog        <= !tog;
    dly_sr     <= {dly_sr[4:0], bus.cn_en && bus.dp_ready};
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks that entries from base on are exp_len indices cycling 0..n-1.
  task automatic check_sweep(input string tag, input int q[$], input int base,
                             input int exp_len, input int n);
    check({tag, " len"}, 32'(q.size() - base), 32'(exp_len));
    for (int i = 0; i < exp_len && base + i < q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(q[base + i]), 32'(i % n));
  endtask

  // Pulses start, then waits (bounded) for done; poke re-pulses start
  // while busy. Returns at the done cycle with cyc = cycles since start.
  task automatic run_decode(input int poke, output int cyc);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 300) begin
      bus.start = (cyc == poke);
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  int lb, cb, vb, leb, ceb, hb, sb, db, cyc;

  task automatic snap();
    lb = ld_log.size(); cb = cn_log.size(); vb = vn_log.size();
    leb = ld_en_cyc; ceb = cn_en_cyc; hb = hold_bad; sb = stalls; db = done_cnt;
  endtask

  task automatic check_end(input string tag, input int conv, input int iters);
    check({tag, " done"},      32'(bus.done), 32'd1);
    check({tag, " converged"}, 32'(bus.converged), 32'(conv));
    check({tag, " iter_cnt"},  32'(bus.iter_cnt), 32'(iters));
    @(posedge clk); #1;
    check({tag, " done 1cyc"}, 32'(bus.done), 32'd0);
    check({tag, " idle"},      32'(bus.busy), 32'd0);
    check({tag, " conv held"}, 32'(bus.converged), 32'(conv));
    check({tag, " iter held"}, 32'(bus.iter_cnt), 32'(iters));
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; bus.start = 1'b0;
    ready_v = 1'b1; bp_mode = 1'b0; dly_mode = 1'b0; resp_ok = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst ld_en", 32'(bus.ld_en), 32'd0);
    check("rst cn_en", 32'(bus.cn_en), 32'd0);
    check("rst vn_en", 32'(bus.vn_en), 32'd0);
    check("rst iter", 32'(bus.iter_cnt), 32'd0);
    check("rst conv", 32'(bus.converged), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle no start", 32'(bus.busy), 32'd0);

    // Abort a decode mid-CN sweep with a mid-cycle reset.
    bus.start = 1'b1; @(posedge clk); #1; bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre-abort busy", 32'(bus.busy), 32'd1);
    check("pre-abort cn_en", 32'(bus.cn_en), 32'd1);
    db = done_cnt;
    #3 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort cn_en", 32'(bus.cn_en), 32'd0);
    check("abort ld_addr", 32'(bus.ld_addr), 32'd0);
    check("abort cn_addr", 32'(bus.cn_addr), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post-abort busy", 32'(bus.busy), 32'd0);
    check("abort no done", 32'(done_cnt - db), 32'd0);

    // Immediate convergence.
    snap(); resp_ok = 1'b1;
    run_decode(-1, cyc);
    check("conv latency", 32'(cyc), EARLY ? 32'd8 : 32'd29);
    check("conv ld cycles", 32'(ld_en_cyc - leb), 32'd4);
    check("conv cn cycles", 32'(cn_en_cyc - ceb), EARLY ? 32'd2 : 32'd8);
    check_sweep("conv ld", ld_log, lb, 4, N_VN);
    check_sweep("conv cn", cn_log, cb, EARLY ? 2 : 8, N_CN);
    check_sweep("conv vn", vn_log, vb, EARLY ? 0 : 12, N_VN);
    check_end("conv", 1, EARLY ? 0 : 3);

    // Never converges.
    snap(); resp_ok = 1'b0;
    run_decode(-1, cyc);
    check("nc latency", 32'(cyc), 32'd29);
    check_sweep("nc cn", cn_log, cb, 8, N_CN);
    check_sweep("nc vn", vn_log, vb, 12, N_VN);
    check_end("nc", 0, 3);

    // Backpressure on VN sweeps.
    snap(); resp_ok = 1'b0; bp_mode = 1'b1;
    run_decode(-1, cyc);
    bp_mode = 1'b0;
    check("bp stalls seen", 32'(stalls - sb > 0), 32'd1);
    check("bp addr held", 32'(hold_bad - hb), 32'd0);
    check_sweep("bp vn", vn_log, vb, 12, N_VN);
    check_end("bp", 0, 3);

    // Delayed responses, extra response, start while busy.
    snap(); resp_ok = 1'b1; dly_mode = 1'b1;
    run_decode(3, cyc);
    check("dly latency", 32'(cyc), EARLY ? 32'd12 : 32'd45);
    check_sweep("dly ld", ld_log, lb, 4, N_VN);
    check_end("dly", 1, EARLY ? 0 : 3);
    dly_mode = 1'b0;
    check("dly one done", 32'(done_cnt - db), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ldpc_iter_sched.md
Name: ldpc_iter_sched

Overview:
- Iteration scheduler for a flooding LDPC decoder.
- Sequences channel-LLR loading, check-node (CN) sweeps and variable-node (VN) sweeps over shared node datapaths (VN unit: 3 channel inputs, 3 outputs, belief).
- Collects per-check parity results to form the syndrome, counts iterations, and stops on zero syndrome or the iteration limit.

Parameters:
- N_VN, 16, number of variable nodes swept per VN phase.
- N_CN, 8, number of check nodes swept per CN phase.
- MAX_ITER, 10, maximum VN phases before forced stop (≥1).
- ADDR_W, 5, address width; ≥ clog2(max(N_VN,N_CN)).
- ITER_W, 4, iteration counter width; ≥ clog2(MAX_ITER+1).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a decode; sampled only in IDLE.
- dp_ready  in  1  datapath accepts the issued command this cycle.
- ld_en  out  1  channel-LLR load command valid.
- ld_addr  out  ADDR_W  VN index to load.
- cn_en  out  1  CN update command valid.
- cn_addr  out  ADDR_W  CN index.
- vn_en  out  1  VN update command valid.
- vn_addr  out  ADDR_W  VN index.
- cn_rsp_valid  in  1  one CN parity result returned.
- cn_parity_ok  in  1  parity of returned check satisfied; qualified by cn_rsp_valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at decode end.
- converged  out  1  final syndrome was all-zero; held until next start.
- iter_cnt  out  ITER_W  completed VN phases; held until next start.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all en, addresses, done, converged, iter_cnt, busy = 0; response counter and syndrome flag cleared.
- Handshake: a command transfers when its en && dp_ready in the same cycle. en and address are registered and held stable until transfer. The address increments by 1 per transfer. After index N-1 transfers, en drops in the next cycle.
- FSM states: IDLE, LOAD, CN_ISSUE, CN_WAIT, VN_ISSUE, FIN.
  - IDLE: on start, clear iter_cnt, converged, counters; go to LOAD.
  - LOAD: issue ld_addr 0..N_VN-1, then go to CN_ISSUE.
  - CN_ISSUE: issue cn_addr 0..N_CN-1. On entry, clear rsp_cnt and set syn_ok=1. After the last transfer, go to CN_WAIT.
  - Response counting (CN_ISSUE and CN_WAIT): each cn_rsp_valid increments rsp_cnt. syn_ok &= cn_parity_ok.
  - CN_WAIT: when rsp_cnt == N_CN, including a response arriving that same cycle, evaluate:
    - syn_ok=1 → FIN with converged=1.
    - else iter_cnt == MAX_ITER → FIN with converged=0.
    - else → VN_ISSUE.
  - VN_ISSUE: issue vn_addr 0..N_VN-1. On the last transfer, iter_cnt += 1; go to CN_ISSUE.
  - FIN: done=1 for exactly one cycle; next cycle go to IDLE.
- Latency: with dp_ready=1 and zero-latency responses, LOAD takes N_VN cycles and CN_ISSUE takes N_CN cycles.
- Ignored inputs:
  - cn_rsp_valid outside CN_ISSUE/CN_WAIT.
  - Responses beyond N_CN (rsp_cnt saturates).
  - start while busy.
- iter_cnt never exceeds MAX_ITER.
- Reset mid-operation aborts immediately; no done pulse.

Optional Feature:
- Macro LDPC_EARLY_TERM_EN.
- Defined: zero-syndrome exit from CN_WAIT as above.
- Undefined: CN_WAIT exits only when iter_cnt == MAX_ITER (always MAX_ITER VN phases). converged still reports syn_ok of the final CN sweep.

Decomposition:
- Shared package ldpc_pkg holds:
  - state enum type;
  - clog2-based width helper;
  - default N_VN/N_CN/MAX_ITER constants shared with the VN/CN datapaths.
- One sub-module, ldpc_addr_seq: a handshaked index sequencer (start, en/ready, last, addr, configurable count). Instantiated for the LOAD, CN and VN sweeps, or once and muxed.

Test Plan (N_VN=4, N_CN=2, MAX_ITER=3, macro defined unless noted):
- Reset: rst_n low mid-cycle → all outputs 0 immediately, state IDLE; after release with start=0, busy stays 0.
- Immediate convergence: start, dp_ready=1, both responses ok → ld_addr 0,1,2,3; cn_addr 0,1; done pulse; converged=1; iter_cnt=0.
- Never converges: parity_ok=0 always → 3 VN sweeps of 0..3; 4 CN sweeps; done with converged=0, iter_cnt=3.
- Backpressure: dp_ready alternating 1/0 during VN_ISSUE → vn_addr holds through each 0 cycle; each index 0..3 transfers exactly once.
- Delayed/extra responses: responses arrive 5 cycles after issue plus one spurious extra → CN_WAIT waits; the extra is ignored; start pulsed during busy is ignored.
- Macro undefined, all parity ok → still iter_cnt=3 at done; converged=1.
